// File: rtl/flash_pkg.sv
// -----------------------------------------------------------------------------
// flash_pkg
//   Definitions shared by the SPI-flash access path.
//   - arb_state_e : arbiter sequencing state (IDLE -> ISSUE -> BUSY -> DONE)
//   - OP_*        : flash command opcodes used by the flash wrapper
//   - *_DEF       : default address / byte-count widths
// -----------------------------------------------------------------------------
package flash_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int CNT_W_DEF  = 8;

   localparam logic [7:0] OP_READ_STATUS  = 8'h05;
   localparam logic [7:0] OP_WRITE_ENABLE = 8'h06;
   localparam logic [7:0] OP_PAGE_PROGRAM = 8'h02;
   localparam logic [7:0] OP_READ_DATA    = 8'h03;
   localparam logic [7:0] OP_SECTOR_ERASE = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/flash_access_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin pick.
//   Ports:
//     valid0, valid1 : in  - requester has a pending op
//     last_gnt       : in  - index of the requester served most recently
//     gnt_valid      : out - at least one requester is pending
//     gnt_idx        : out - winning requester index (0/1)
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_gnt,
   output logic gnt_valid,
   output logic gnt_idx
);

   always_comb begin
      gnt_valid = valid0 | valid1;
      // On a tie the requester not served last wins; otherwise the lone one.
      if (valid0 && valid1) begin
         gnt_idx = ~last_gnt;
      end else begin
         gnt_idx = valid1;
      end
   end

endmodule

// File: rtl/flash_access_arbiter.sv
// -----------------------------------------------------------------------------
// flash_access_arbiter
//   Shares one SPI-flash wrapper port between req0 (boot loader) and req1
//   (data/CPU store path). Round-robin grant, latches the winning payload and
//   drives the wrapper's read/write strobes, then follows the wrapper through
//   IDLE -> busy -> IDLE and returns done (and err on timeout) to the winner.
//
//   Handshake: a requester holds reqN_valid with a stable payload until it sees
//   the one-cycle reqN_ready pulse; that pulse means the payload was latched and
//   the op is owned by the arbiter. reqN_done (with reqN_err on timeout) pulses
//   exactly once per accepted op, only to the requester that was granted.
//
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     reqN_valid/write/addr/nbyte : requester N op (write=1 erase+program)
//     reqN_ready/done/err      : one-cycle pulses back to requester N
//     wp_read, wp_write        : level strobes to the wrapper (ISSUE only)
//     wp_addr, wp_nbyte        : latched payload, held from grant until DONE
//     wp_idle                  : wrapper FSM is in its IDLE state
//     dbg_state                : current arbiter state
// -----------------------------------------------------------------------------
module flash_access_arbiter
   import flash_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [CNT_W-1:0]  req0_nbyte,
   output logic              req0_ready,
   output logic              req0_done,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [CNT_W-1:0]  req1_nbyte,
   output logic              req1_ready,
   output logic              req1_done,
   output logic              req1_err,
   output logic              wp_read,
   output logic              wp_write,
   output logic [ADDR_W-1:0] wp_addr,
   output logic [CNT_W-1:0]  wp_nbyte,
   input  logic              wp_idle,
   output arb_state_e        dbg_state
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);

   arb_state_e        state_q, state_d;
   logic              last_gnt_q, last_gnt_d;
   logic              gnt_q, gnt_d;
   logic              op_write_q, op_write_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic              wp_read_q, wp_read_d;
   logic              wp_write_q, wp_write_d;
   logic [ADDR_W-1:0] wp_addr_q, wp_addr_d;
   logic [CNT_W-1:0]  wp_nbyte_q, wp_nbyte_d;
   logic              ready0_q, ready0_d, ready1_q, ready1_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              err0_q, err0_d, err1_q, err1_d;

   logic              arb_valid;
   logic              arb_idx;

   rr_arb2 u_rr_arb2 (
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .last_gnt  (last_gnt_q),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
   );

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      op_write_d = op_write_q;
      timer_d    = timer_q;
      wp_read_d  = wp_read_q;
      wp_write_d = wp_write_q;
      wp_addr_d  = wp_addr_q;
      wp_nbyte_d = wp_nbyte_q;
      ready0_d   = 1'b0;
      ready1_d   = 1'b0;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      err0_d     = 1'b0;
      err1_d     = 1'b0;

      if ((state_q == ST_ISSUE || state_q == ST_BUSY) && timer_q != TO_MAX) begin
         timer_d = timer_q + TO_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            // A busy wrapper in IDLE means someone else still owns it: hold off.
            if (arb_valid && wp_idle) begin
               gnt_d      = arb_idx;
               op_write_d = arb_idx ? req1_write : req0_write;
               wp_addr_d  = arb_idx ? req1_addr  : req0_addr;
               wp_nbyte_d = arb_idx ? req1_nbyte : req0_nbyte;
               ready0_d   = ~arb_idx;
               ready1_d   = arb_idx;
               timer_d    = '0;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (timer_q == TO_LAST) begin
               wp_read_d  = 1'b0;
               wp_write_d = 1'b0;
               done0_d    = ~gnt_q;
               done1_d    = gnt_q;
               err0_d     = ~gnt_q;
               err1_d     = gnt_q;
               state_d    = ST_DONE;
            end else if (!wp_idle) begin
               // Wrapper has taken the command; strobe must be gone before it
               // returns to IDLE or it would start a second op.
               wp_read_d  = 1'b0;
               wp_write_d = 1'b0;
               state_d    = ST_BUSY;
            end else begin
               wp_read_d  = ~op_write_q;
               wp_write_d = op_write_q;
            end
         end
         ST_BUSY: begin
            wp_read_d  = 1'b0;
            wp_write_d = 1'b0;
            if (timer_q == TO_LAST) begin
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               err0_d  = ~gnt_q;
               err1_d  = gnt_q;
               state_d = ST_DONE;
            end else if (wp_idle) begin
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // No grant here: the wrapper gets one IDLE cycle to reload address/count.
            last_gnt_d = gnt_q;
            wp_addr_d  = '0;
            wp_nbyte_d = '0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         op_write_q <= 1'b0;
         timer_q    <= '0;
         wp_read_q  <= 1'b0;
         wp_write_q <= 1'b0;
         wp_addr_q  <= '0;
         wp_nbyte_q <= '0;
         ready0_q   <= 1'b0;
         ready1_q   <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         op_write_q <= op_write_d;
         timer_q    <= timer_d;
         wp_read_q  <= wp_read_d;
         wp_write_q <= wp_write_d;
         wp_addr_q  <= wp_addr_d;
         wp_nbyte_q <= wp_nbyte_d;
         ready0_q   <= ready0_d;
         ready1_q   <= ready1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         err0_q     <= err0_d;
         err1_q     <= err1_d;
      end
   end

   assign req0_ready = ready0_q;
   assign req1_ready = ready1_q;
   assign req0_done  = done0_q;
   assign req1_done  = done1_q;
   assign req0_err   = err0_q;
   assign req1_err   = err1_q;
   assign wp_read    = wp_read_q;
   assign wp_write   = wp_write_q;
   assign wp_addr    = wp_addr_q;
   assign wp_nbyte   = wp_nbyte_q;
   assign dbg_state  = state_q;

endmodule
